// File: rtl/pcpi_gf_pkg.sv
// Shared types and constants for the two-core PCPI Galois coprocessor arbiter.
// Arbiter state encoding, default custom-0 opcode match, and completed-grant counter width.
// Also hosts the request-match helper used by the top level.
package pcpi_gf_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_BUSY    = 2'd1,
        ST_RELEASE = 2'd2
    } state_t;

    localparam logic [31:0] DEF_INSN_MASK  = 32'h0000_007F;
    localparam logic [31:0] DEF_INSN_MATCH = 32'h0000_000B;
    localparam int          GRANT_CNT_W    = 16;

    // True when the masked instruction bits select the coprocessor.
    function automatic logic insn_hits(input logic [31:0] insn,
                                       input logic [31:0] mask,
                                       input logic [31:0] match);
        return (insn & mask) == match;
    endfunction

endpackage

// File: rtl/pcpi_rr_arb2.sv
// Two-requester round-robin picker; rr_ptr names the winner of the next contention.
// Zero latency: pick is combinational from req and the registered pointer.
// Pointer only moves when the caller takes a decision with both requests present.
module pcpi_rr_arb2 (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       take,
    output logic       pick
);

    logic rr_ptr;

    // Winner selection: a lone requester wins outright, contention follows the pointer.
    always_comb begin
        pick = 1'b0;
        if (req == 2'b11) begin
            pick = rr_ptr;
        end else if (req[1]) begin
            pick = 1'b1;
        end
    end

    // Pointer hands priority to the losing core after each contended arbitration.
    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr <= 1'b0;
        end else if (take && (req == 2'b11)) begin
            rr_ptr <= ~rr_ptr;
        end
    end

endmodule

// File: rtl/pcpi_gf_arbiter.sv
// Shares one PCPI Galois coprocessor between two picorv32 cores, round-robin on contention.
// Grant one cycle after a match is seen in IDLE; owner's ready/wr/rd pass through with zero latency.
// Waiting cores see pcpi_wait so their PCPI timeout never fires; one dead cycle after each grant.
module pcpi_gf_arbiter
    import pcpi_gf_pkg::*;
#(
    parameter int                     DATA_WIDTH     = 32,
    parameter logic [31:0]            INSN_MASK      = DEF_INSN_MASK,
    parameter logic [31:0]            INSN_MATCH     = DEF_INSN_MATCH,
    // Value the completed-grant counter takes on reset.
    parameter logic [GRANT_CNT_W-1:0] GRANT_CNT_INIT = '0
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   up0_valid,
    input  logic [31:0]            up0_insn,
    input  logic [DATA_WIDTH-1:0]  up0_rs1,
    input  logic [DATA_WIDTH-1:0]  up0_rs2,
    output logic                   up0_wr,
    output logic [DATA_WIDTH-1:0]  up0_rd,
    output logic                   up0_wait,
    output logic                   up0_ready,
    input  logic                   up1_valid,
    input  logic [31:0]            up1_insn,
    input  logic [DATA_WIDTH-1:0]  up1_rs1,
    input  logic [DATA_WIDTH-1:0]  up1_rs2,
    output logic                   up1_wr,
    output logic [DATA_WIDTH-1:0]  up1_rd,
    output logic                   up1_wait,
    output logic                   up1_ready,
    output logic                   dn_valid,
    output logic [31:0]            dn_insn,
    output logic [DATA_WIDTH-1:0]  dn_rs1,
    output logic [DATA_WIDTH-1:0]  dn_rs2,
    input  logic                   dn_wr,
    input  logic [DATA_WIDTH-1:0]  dn_rd,
    input  logic                   dn_wait,
    input  logic                   dn_ready,
    output logic [GRANT_CNT_W-1:0] grant_count
);

    state_t                state_q, state_d;
    logic                  owner_q, owner_d;
    logic                  cnt_inc;
    logic                  match0, match1;
    logic                  pick;
    logic                  busy;
    logic                  own0, own1;
    logic                  own_valid;
    logic [31:0]           own_insn;
    logic [DATA_WIDTH-1:0] own_rs1, own_rs2;

    assign match0 = up0_valid && insn_hits(up0_insn, INSN_MASK, INSN_MATCH);
    assign match1 = up1_valid && insn_hits(up1_insn, INSN_MASK, INSN_MATCH);

    pcpi_rr_arb2 u_rr (
        .clk   (clk),
        .reset (reset),
        .req   ({match1, match0}),
        .take  (state_q == ST_IDLE),
        .pick  (pick)
    );

    // Owner-side request mux, driven from the registered owner.
    always_comb begin
        own_valid = owner_q ? up1_valid : up0_valid;
        own_insn  = owner_q ? up1_insn  : up0_insn;
        own_rs1   = owner_q ? up1_rs1   : up0_rs1;
        own_rs2   = owner_q ? up1_rs2   : up0_rs2;
    end

    // Next-state logic: arbitrate in IDLE, finish or abort in BUSY, one dead cycle in RELEASE.
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        cnt_inc = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (match0 || match1) begin
                    state_d = ST_BUSY;
                    owner_d = pick;
                end
            end
            ST_BUSY: begin
                if (dn_ready) begin
                    state_d = ST_RELEASE;
                    cnt_inc = 1'b1;
                end else if (!own_valid) begin
                    state_d = ST_RELEASE;
                end
            end
            ST_RELEASE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, owner and completed-grant counter registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            owner_q     <= 1'b0;
            grant_count <= GRANT_CNT_INIT;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            if (cnt_inc) begin
                grant_count <= grant_count + 1'b1;
            end
        end
    end

    assign busy = (state_q == ST_BUSY);
    assign own0 = busy && !owner_q;
    assign own1 = busy &&  owner_q;

    // Output muxing: coprocessor sees only the owner in BUSY; responses reach only the owner.
    always_comb begin
        dn_valid  = busy && own_valid;
        dn_insn   = busy ? own_insn : '0;
        dn_rs1    = busy ? own_rs1  : '0;
        dn_rs2    = busy ? own_rs2  : '0;

        up0_ready = own0 && dn_ready;
        up0_wr    = own0 && dn_wr;
        up0_rd    = own0 ? dn_rd : '0;
        up1_ready = own1 && dn_ready;
        up1_wr    = own1 && dn_wr;
        up1_rd    = own1 ? dn_rd : '0;

        // Keep any matching core stalled until its ready arrives; owner also honours dn_wait.
        up0_wait  = (match0 || (own0 && dn_wait)) && !up0_ready;
        up1_wait  = (match1 || (own1 && dn_wait)) && !up1_ready;
    end

endmodule

// File: tb/tb_pcpi_gf_arbiter.sv
// Directed bench for pcpi_gf_arbiter: cycle table plus abort, reset and counter-wrap sequences.
// Inputs change 1ns after the rising edge; outputs are sampled 1ns later, before the next edge.
// A second instance with a preloaded counter exercises the 0xFFFF -> 0 wrap.
module tb_pcpi_gf_arbiter;

    localparam logic [31:0] I = 32'h0020C08B;
    localparam logic [31:0] J = 32'h0000100B;
    localparam logic [31:0] N = 32'h00000033;
    localparam logic [31:0] Z = 32'h0;

    logic        clk = 1'b0;
    logic        reset;
    logic        up0_valid, up1_valid;
    logic [31:0] up0_insn, up1_insn;
    logic [31:0] up0_rs1, up0_rs2, up1_rs1, up1_rs2;
    logic        up0_wr, up1_wr, up0_wait, up1_wait, up0_ready, up1_ready;
    logic [31:0] up0_rd, up1_rd;
    logic        dn_valid;
    logic [31:0] dn_insn, dn_rs1, dn_rs2;
    logic        dn_wr, dn_wait, dn_ready;
    logic [31:0] dn_rd;
    logic [15:0] grant_count;

    logic        b_v0, b_rdy;
    logic        b_wr0, b_wr1, b_w0, b_w1, b_r0, b_r1, b_dnv;
    logic [31:0] b_rd0, b_rd1, b_dninsn, b_dnrs1, b_dnrs2;
    logic [15:0] b_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pcpi_gf_arbiter dut (
        .clk(clk), .reset(reset),
        .up0_valid(up0_valid), .up0_insn(up0_insn), .up0_rs1(up0_rs1), .up0_rs2(up0_rs2),
        .up0_wr(up0_wr), .up0_rd(up0_rd), .up0_wait(up0_wait), .up0_ready(up0_ready),
        .up1_valid(up1_valid), .up1_insn(up1_insn), .up1_rs1(up1_rs1), .up1_rs2(up1_rs2),
        .up1_wr(up1_wr), .up1_rd(up1_rd), .up1_wait(up1_wait), .up1_ready(up1_ready),
        .dn_valid(dn_valid), .dn_insn(dn_insn), .dn_rs1(dn_rs1), .dn_rs2(dn_rs2),
        .dn_wr(dn_wr), .dn_rd(dn_rd), .dn_wait(dn_wait), .dn_ready(dn_ready),
        .grant_count(grant_count)
    );

    pcpi_gf_arbiter #(.GRANT_CNT_INIT(16'hFFFE)) dut_wrap (
        .clk(clk), .reset(reset),
        .up0_valid(b_v0), .up0_insn(I), .up0_rs1(Z), .up0_rs2(Z),
        .up0_wr(b_wr0), .up0_rd(b_rd0), .up0_wait(b_w0), .up0_ready(b_r0),
        .up1_valid(1'b0), .up1_insn(Z), .up1_rs1(Z), .up1_rs2(Z),
        .up1_wr(b_wr1), .up1_rd(b_rd1), .up1_wait(b_w1), .up1_ready(b_r1),
        .dn_valid(b_dnv), .dn_insn(b_dninsn), .dn_rs1(b_dnrs1), .dn_rs2(b_dnrs2),
        .dn_wr(b_rdy), .dn_rd(32'h0000_0042), .dn_wait(1'b0), .dn_ready(b_rdy),
        .grant_count(b_cnt)
    );

    typedef struct {
        logic        v0;
        logic [31:0] i0;
        logic        v1;
        logic [31:0] i1;
        logic        rdy;     // dn_ready and dn_wr together
        logic [31:0] rd;
        logic        e_dnv;
        logic [31:0] e_insn;
        logic        e_w0;
        logic        e_w1;
        logic        e_r0;
        logic        e_r1;
        logic [31:0] e_rd0;
        logic [31:0] e_rd1;
        logic [15:0] e_cnt;
    } vec_t;

    vec_t tbl [24];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic v0, input logic [31:0] i0, input logic v1,
                         input logic [31:0] i1, input logic rdy, input logic [31:0] rd);
        up0_valid = v0; up0_insn = i0;
        up1_valid = v1; up1_insn = i1;
        dn_ready  = rdy; dn_wr = rdy; dn_rd = rd;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        drive(0, Z, 0, Z, 0, Z);
        dn_wait = 1'b0;
        up0_rs1 = 32'd31; up0_rs2 = 32'd1020;
        up1_rs1 = 32'd5;  up1_rs2 = 32'd7;
        b_v0 = 1'b0; b_rdy = 1'b0;

        // Cycle table: single request, two contended pairs, non-matching and stray responses.
        tbl[0]  = '{1, I, 0, Z, 0, Z,            0, Z, 1, 0, 0, 0, Z, Z, 16'd0};
        tbl[1]  = '{1, I, 0, Z, 0, Z,            1, I, 1, 0, 0, 0, Z, Z, 16'd0};
        tbl[2]  = '{1, I, 0, Z, 0, Z,            1, I, 1, 0, 0, 0, Z, Z, 16'd0};
        tbl[3]  = '{1, I, 0, Z, 0, Z,            1, I, 1, 0, 0, 0, Z, Z, 16'd0};
        tbl[4]  = '{1, I, 0, Z, 1, 32'h1234,     1, I, 0, 0, 1, 0, 32'h1234, Z, 16'd0};
        tbl[5]  = '{0, Z, 0, Z, 0, Z,            0, Z, 0, 0, 0, 0, Z, Z, 16'd1};
        tbl[6]  = '{1, I, 1, J, 0, Z,            0, Z, 1, 1, 0, 0, Z, Z, 16'd1};
        tbl[7]  = '{1, I, 1, J, 0, Z,            1, I, 1, 1, 0, 0, Z, Z, 16'd1};
        tbl[8]  = '{1, I, 1, J, 1, 32'hAAAA,     1, I, 0, 1, 1, 0, 32'hAAAA, Z, 16'd1};
        tbl[9]  = '{0, Z, 1, J, 0, Z,            0, Z, 0, 1, 0, 0, Z, Z, 16'd2};
        tbl[10] = '{0, Z, 1, J, 0, Z,            0, Z, 0, 1, 0, 0, Z, Z, 16'd2};
        tbl[11] = '{0, Z, 1, J, 1, 32'h5555,     1, J, 0, 0, 0, 1, Z, 32'h5555, 16'd2};
        tbl[12] = '{0, Z, 0, Z, 0, Z,            0, Z, 0, 0, 0, 0, Z, Z, 16'd3};
        tbl[13] = '{1, I, 1, J, 0, Z,            0, Z, 1, 1, 0, 0, Z, Z, 16'd3};
        tbl[14] = '{1, I, 1, J, 0, Z,            1, J, 1, 1, 0, 0, Z, Z, 16'd3};
        tbl[15] = '{1, I, 1, J, 1, 32'h0BB0,     1, J, 1, 0, 0, 1, Z, 32'h0BB0, 16'd3};
        tbl[16] = '{1, I, 0, Z, 0, Z,            0, Z, 1, 0, 0, 0, Z, Z, 16'd4};
        tbl[17] = '{1, I, 0, Z, 0, Z,            0, Z, 1, 0, 0, 0, Z, Z, 16'd4};
        tbl[18] = '{1, I, 0, Z, 1, 32'h0CC0,     1, I, 0, 0, 1, 0, 32'h0CC0, Z, 16'd4};
        tbl[19] = '{0, Z, 0, Z, 0, Z,            0, Z, 0, 0, 0, 0, Z, Z, 16'd5};
        tbl[20] = '{0, Z, 1, N, 0, Z,            0, Z, 0, 0, 0, 0, Z, Z, 16'd5};
        tbl[21] = '{0, Z, 1, N, 0, Z,            0, Z, 0, 0, 0, 0, Z, Z, 16'd5};
        tbl[22] = '{0, Z, 1, N, 1, 32'hDEAD,     0, Z, 0, 0, 0, 0, Z, Z, 16'd5};
        tbl[23] = '{0, Z, 0, Z, 1, 32'hDEAD,     0, Z, 0, 0, 0, 0, Z, Z, 16'd5};

        // Reset state.
        next_cycle();
        next_cycle();
        chk("rst_dn_valid", {31'd0, dn_valid}, 32'd0);
        chk("rst_dn_insn", dn_insn, 32'd0);
        chk("rst_dn_rs1", dn_rs1, 32'd0);
        chk("rst_up_ready", {30'd0, up1_ready, up0_ready}, 32'd0);
        chk("rst_up_wait", {30'd0, up1_wait, up0_wait}, 32'd0);
        chk("rst_grant_count", {16'd0, grant_count}, 32'd0);
        chk("rst_wrap_count", {16'd0, b_cnt}, 32'h0000FFFE);
        reset = 1'b0;

        for (int k = 0; k < 24; k++) begin
            drive(tbl[k].v0, tbl[k].i0, tbl[k].v1, tbl[k].i1, tbl[k].rdy, tbl[k].rd);
            #1;
            chk($sformatf("t%0d_dn_valid", k), {31'd0, dn_valid}, {31'd0, tbl[k].e_dnv});
            chk($sformatf("t%0d_dn_insn", k), dn_insn, tbl[k].e_insn);
            chk($sformatf("t%0d_up0_wait", k), {31'd0, up0_wait}, {31'd0, tbl[k].e_w0});
            chk($sformatf("t%0d_up1_wait", k), {31'd0, up1_wait}, {31'd0, tbl[k].e_w1});
            chk($sformatf("t%0d_up0_ready", k), {31'd0, up0_ready}, {31'd0, tbl[k].e_r0});
            chk($sformatf("t%0d_up1_ready", k), {31'd0, up1_ready}, {31'd0, tbl[k].e_r1});
            chk($sformatf("t%0d_up0_wr", k), {31'd0, up0_wr}, {31'd0, tbl[k].e_r0});
            chk($sformatf("t%0d_up1_wr", k), {31'd0, up1_wr}, {31'd0, tbl[k].e_r1});
            chk($sformatf("t%0d_up0_rd", k), up0_rd, tbl[k].e_rd0);
            chk($sformatf("t%0d_up1_rd", k), up1_rd, tbl[k].e_rd1);
            chk($sformatf("t%0d_grant_count", k), {16'd0, grant_count}, {16'd0, tbl[k].e_cnt});
            next_cycle();
        end

        // Owner abort: core 0 wins (pointer back at 0), drops valid, core 1 is served next.
        drive(1, I, 1, J, 0, Z);
        next_cycle();
        #1;
        chk("ab_dn_valid_1", {31'd0, dn_valid}, 32'd1);
        chk("ab_dn_insn", dn_insn, I);
        chk("ab_dn_rs1", dn_rs1, 32'd31);
        chk("ab_dn_rs2", dn_rs2, 32'd1020);
        next_cycle();
        chk("ab_dn_valid_2", {31'd0, dn_valid}, 32'd1);
        next_cycle();
        drive(0, Z, 1, J, 0, Z);
        #1;
        chk("ab_drop_dn_valid", {31'd0, dn_valid}, 32'd0);
        chk("ab_drop_up1_wait", {31'd0, up1_wait}, 32'd1);
        next_cycle();
        chk("ab_release_dn_valid", {31'd0, dn_valid}, 32'd0);
        chk("ab_release_count", {16'd0, grant_count}, 32'd5);
        next_cycle();
        chk("ab_idle_dn_valid", {31'd0, dn_valid}, 32'd0);
        chk("ab_idle_up1_wait", {31'd0, up1_wait}, 32'd1);
        next_cycle();
        drive(0, Z, 1, J, 1, 32'h0077);
        #1;
        chk("ab_next_dn_insn", dn_insn, J);
        chk("ab_next_dn_rs1", dn_rs1, 32'd5);
        chk("ab_next_up1_ready", {31'd0, up1_ready}, 32'd1);
        chk("ab_next_up1_rd", up1_rd, 32'h0077);
        next_cycle();
        drive(0, Z, 0, Z, 0, Z);
        #1;
        chk("ab_final_count", {16'd0, grant_count}, 32'd6);

        // Reset while BUSY, then stray responses that must not be forwarded.
        next_cycle();
        drive(1, I, 0, Z, 0, Z);
        next_cycle();
        chk("rm_busy_dn_valid", {31'd0, dn_valid}, 32'd1);
        reset = 1'b1;
        next_cycle();
        reset = 1'b0;
        drive(0, Z, 0, Z, 1, 32'hFFFF);
        #1;
        chk("rm_dn_valid", {31'd0, dn_valid}, 32'd0);
        chk("rm_grant_count", {16'd0, grant_count}, 32'd0);
        chk("rm_stray_ready", {30'd0, up1_ready, up0_ready}, 32'd0);
        chk("rm_stray_rd0", up0_rd, 32'd0);
        next_cycle();
        chk("rm_stray_ready_2", {30'd0, up1_ready, up0_ready}, 32'd0);
        chk("rm_stray_wr_2", {30'd0, up1_wr, up0_wr}, 32'd0);
        chk("rm_count_2", {16'd0, grant_count}, 32'd0);
        drive(0, Z, 0, Z, 0, Z);

        // Counter wrap on the preloaded instance: 0xFFFE -> 0xFFFF -> 0x0000.
        for (int g = 0; g < 2; g++) begin
            b_v0 = 1'b1;
            next_cycle();
            b_rdy = 1'b1;
            #1;
            chk($sformatf("wrap%0d_ready", g), {31'd0, b_r0}, 32'd1);
            next_cycle();
            b_v0 = 1'b0;
            b_rdy = 1'b0;
            #1;
            chk($sformatf("wrap%0d_count", g), {16'd0, b_cnt}, (g == 0) ? 32'h0000FFFF : 32'h0);
            next_cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pcpi_gf_arbiter.md
# pcpi_gf_arbiter

Two-port PCPI arbiter that lets two picorv32 cores share one `picorv32_pcpi_galois` coprocessor. It sits between the cores' PCPI master ports and the coprocessor's PCPI slave port. It grants the coprocessor to one matching request at a time, in round-robin order, and holds the grant until the coprocessor answers. While a core is waiting it asserts `pcpi_wait` to that core, so the core's PCPI timeout cannot expire and raise an illegal-instruction trap.

## Interface
- `DATA_WIDTH`, 32: width of rs1, rs2 and rd.
- `INSN_MASK`, 32'h0000007F: insn bits compared when deciding whether a request targets the coprocessor.
- `INSN_MATCH`, 32'h0000000B: required value of the masked insn bits (custom-0 opcode).
- `clk`  in  1: single clock; all logic on its rising edge.
- `reset`  in  1: synchronous, active-high.
- `up0_valid`, `up1_valid`  in  1: PCPI valid from core 0 / core 1.
- `up0_insn`, `up1_insn`  in  32: instruction from each core.
- `up0_rs1`, `up0_rs2`, `up1_rs1`, `up1_rs2`  in  DATA_WIDTH: operands from each core.
- `up0_wr`, `up1_wr`  out  1: result-write flag returned to each core.
- `up0_rd`, `up1_rd`  out  DATA_WIDTH: result returned to each core.
- `up0_wait`, `up1_wait`  out  1: PCPI wait to each core.
- `up0_ready`, `up1_ready`  out  1: PCPI ready to each core.
- `dn_valid`  out  1: valid to the coprocessor.
- `dn_insn`  out  32: instruction to the coprocessor.
- `dn_rs1`, `dn_rs2`  out  DATA_WIDTH: operands to the coprocessor.
- `dn_wr`, `dn_rd`, `dn_wait`, `dn_ready`  in  1 / DATA_WIDTH / 1 / 1: coprocessor response.
- `grant_count`  out  16: number of completed grants; wraps from 0xFFFF to 0.

## Operation
- A request is **matching** when `upN_valid` is high and `(upN_insn & INSN_MASK) == INSN_MATCH`.
- Non-matching requests are never granted and receive no wait or ready, so the core traps normally.
- States:
  - IDLE: no owner.
  - BUSY: owner holds the coprocessor.
  - RELEASE: one-cycle gap after a grant ends.
- IDLE:
  - If exactly one request matches, that core becomes owner and the state moves to BUSY.
  - If both match, the owner is the core selected by `rr_ptr`, and `rr_ptr` becomes the other core.
  - With no matching request, the state stays IDLE.
- BUSY:
  - `dn_valid` = owner's valid; `dn_insn`, `dn_rs1` and `dn_rs2` mux the owner's inputs.
  - The owner's wait, ready, wr and rd pass through combinationally from `dn_*`.
  - When `dn_ready` is high, go to RELEASE and increment `grant_count`.
  - If the owner's valid drops before `dn_ready` (core reset or abort), go to RELEASE and do not increment `grant_count`.
- RELEASE: `dn_valid` is forced to 0 for one cycle, so the coprocessor never sees a stale valid. Then go to IDLE.
- `upN_wait` is high whenever core N's request is matching and core N is not receiving ready this cycle. This covers IDLE, RELEASE and the losing core in BUSY.
- The non-owner's ready and wr are always 0, and its rd is 0.
- `dn_ready` or `dn_wr` arriving while not in BUSY is ignored and never forwarded.
- `rr_ptr` changes only on an arbitration with both requests matching. A single matching request does not move it.

## Timing
- Reset values:
  - `dn_valid`=0 and `dn_insn`/`dn_rs1`/`dn_rs2`=0.
  - All `upN_ready`, `upN_wr`, `upN_rd` and `upN_wait` = 0, unless a matching request is present, in which case wait follows the rule above.
  - State=IDLE, `rr_ptr`=0 (core 0 wins first contention), `grant_count`=0.
- Reset during BUSY aborts the transaction. The next cycle is IDLE with `dn_valid`=0.
- Arbitration latency: a match seen in IDLE at cycle t gives `dn_valid`=1 at t+1.
- Response latency: `upN_ready` is asserted in the same cycle as `dn_ready` (zero added latency).
- Back-to-back throughput: the minimum gap between two grants is 2 cycles after `dn_ready`, one for RELEASE and one for IDLE arbitration.
- Owner, `rr_ptr`, state and `grant_count` are registers. Output muxes are combinational from the registered owner.

## Structure
- Package `pcpi_gf_pkg` holds:
  - the state enum (IDLE/BUSY/RELEASE);
  - the default `INSN_MASK`/`INSN_MATCH` constants;
  - the `GRANT_CNT_W`=16 constant.
- One sub-module is natural: `pcpi_rr_arb2`, a two-requester round-robin picker with `rr_ptr`. Everything else lives in the top module.

## Test plan
- Single request:
  - Stimulus: core 0 sends insn 32'h0020C08B, rs1=31, rs2=1020; the coprocessor model answers 3 cycles after `dn_valid` with `dn_ready`=1, `dn_wr`=1, `dn_rd`=32'h00001234.
  - Required: `dn_valid` rises one cycle after `up0_valid`; `up0_ready`/`up0_wr`/`up0_rd`=0x1234 in the same cycle as `dn_ready`; `grant_count`=1.
- Contention:
  - Stimulus: both cores raise matching valid in the same cycle, twice in a row.
  - Required: core 0 is served first and core 1 second; `up1_wait`=1 throughout core 0's service; the next simultaneous pair serves core 1 first.
- Non-matching request:
  - Stimulus: core 1 sends insn 32'h00000033 (ADD).
  - Required: `up1_wait` stays 0, `dn_valid` stays 0, no ready is ever returned.
- Owner abort:
  - Stimulus: core 0 drops valid 2 cycles into BUSY.
  - Required: RELEASE for one cycle with `dn_valid`=0, then IDLE; `grant_count` unchanged; core 1's pending request is granted next.
- Reset mid-op:
  - Stimulus: assert `reset` for 1 cycle while BUSY.
  - Required: `dn_valid`=0 and `grant_count`=0 next cycle; a later stray `dn_ready` is not forwarded to either core.
- Counter wrap:
  - Stimulus: preload or run 65536 grants.
  - Required: `grant_count` returns to 0.
